// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: sequences the shared datapath one instruction at a time,
// driving the datapath mux selects, ALU control and every write enable.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_ctl,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
        JAL    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                           OP_LW    = 6'h23, OP_SW  = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                           ALU_OR  = 3'b001, ALU_SLT = 3'b111;

    // Counter needs at least one bit even when the timeout is disabled.
    localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_MAX  = CW'(MEM_WAIT_MAX);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt;
    logic            mem_state;
    logic            waiting;

    assign state     = state_q;
    assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign waiting   = mem_state && !mem_ready;

    // NOTE: every output and state_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctl    = 3'b000;
        illegal_op = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctl   = ALU_ADD;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_ctl   = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:   state_d = MEMADR;
                    OP_RTYPE:       state_d = EXEC;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_ADDI:        state_d = ADDIEX;
                    OP_J:           state_d = JUMP;
                    OP_JAL:         state_d = JAL;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctl   = ALU_ADD;
                state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                state_d   = ALUWB;
                case (funct)
                    6'h20:   alu_ctl = ALU_ADD;
                    6'h22:   alu_ctl = ALU_SUB;
                    6'h24:   alu_ctl = ALU_AND;
                    6'h25:   alu_ctl = ALU_OR;
                    6'h2A:   alu_ctl = ALU_SLT;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctl   = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = (opcode == OP_BNE) ? !zero : zero;
                state_d   = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctl   = ALU_ADD;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset abandons the current instruction without touching PC, IR, registers or memory.
        if (reset) begin
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_timeout <= 1'b0;
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (MEM_WAIT_MAX != 0 && waiting && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
                // Pulse lands in the cycle the counter reaches the limit; saturation prevents repeats.
                mem_timeout <= (wait_cnt == WAIT_LAST);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through the FSM and
// checks state sequence, control outputs, reset abandonment, wait handling and timeout.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic       alu_src_a;
    logic [2:0] alu_ctl;
    logic       illegal_op, mem_timeout;
    logic [3:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    multicycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctl(alu_ctl),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are inspected 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch with memory ready, leaving the FSM in DECODE.
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        opcode    = op;
        funct     = fn;
        mem_ready = 1'b1;
        #1;
        check("fetch_state", state, 0);
        check("fetch_ir_write", ir_write, 1);
        check("fetch_pc_en", pc_en, 1);
        tick();
        check("decode_state", state, 1);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        tick();
        check("rst_mem_read", mem_read, 0);
        check("rst_pc_en", pc_en, 0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_state", state, 0);
        check("post_rst_mem_read", mem_read, 1);
        check("post_rst_illegal", illegal_op, 0);
        check("post_rst_timeout", mem_timeout, 0);

        // add: FETCH, DECODE, EXEC, ALUWB
        fetch(6'h00, 6'h20);
        check("decode_alu_src_b", alu_src_b, 3);
        tick();
        check("add_exec_state", state, 6);
        check("add_alu_ctl", alu_ctl, 3'b010);
        check("add_alu_src_a", alu_src_a, 1);
        tick();
        check("add_aluwb_state", state, 7);
        check("add_reg_write", reg_write, 1);
        check("add_reg_dst", reg_dst, 1);
        tick();
        check("add_done_state", state, 0);

        // lw with three stall cycles in MEMRD
        fetch(6'h23, 6'h00);
        tick();
        check("lw_memadr_state", state, 2);
        check("lw_memadr_src_b", alu_src_b, 2);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lw_wait_state", state, 3);
            check("lw_wait_mem_read", mem_read, 1);
            check("lw_wait_iord", iord, 1);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("lw_memrd_last", state, 3);
        tick();
        check("lw_memwb_state", state, 4);
        check("lw_memwb_reg_write", reg_write, 1);
        check("lw_memwb_mem_to_reg", mem_to_reg, 1);
        check("lw_no_timeout", mem_timeout, 0);

        // reset held for two cycles starting in MEMWB
        reset = 1'b1;
        #1;
        check("rst_memwb_reg_write", reg_write, 0);
        tick();
        check("rst2_reg_write", reg_write, 0);
        check("rst2_mem_read", mem_read, 0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_abandon_state", state, 0);
        check("rst_abandon_mem_read", mem_read, 1);

        // beq taken on zero=1
        zero = 1'b1;
        fetch(6'h04, 6'h00);
        tick();
        check("beq_state", state, 8);
        check("beq_pc_en", pc_en, 1);
        check("beq_pc_src", pc_src, 1);
        check("beq_alu_ctl", alu_ctl, 3'b110);
        tick();
        check("beq_done", state, 0);

        // bne not taken on zero=1, taken on zero=0
        fetch(6'h05, 6'h00);
        tick();
        check("bne_state", state, 8);
        check("bne_z1_pc_en", pc_en, 0);
        zero = 1'b0;
        #1;
        check("bne_z0_pc_en", pc_en, 1);
        tick();
        check("bne_done", state, 0);

        // unsupported opcode
        fetch(6'h3F, 6'h00);
        check("illop_pulse", illegal_op, 1);
        check("illop_reg_write", reg_write, 0);
        check("illop_mem_write", mem_write, 0);
        check("illop_pc_en", pc_en, 0);
        tick();
        check("illop_next", state, 0);
        check("illop_cleared", illegal_op, 0);

        // unsupported funct
        fetch(6'h00, 6'h21);
        tick();
        check("illfn_exec", state, 6);
        check("illfn_pulse", illegal_op, 1);
        tick();
        check("illfn_next", state, 0);

        // jal
        fetch(6'h03, 6'h00);
        tick();
        check("jal_state", state, 12);
        check("jal_pc_en", pc_en, 1);
        check("jal_reg_write", reg_write, 1);
        check("jal_reg_dst", reg_dst, 2);
        check("jal_mem_to_reg", mem_to_reg, 2);
        check("jal_pc_src", pc_src, 2);
        tick();
        check("jal_done", state, 0);

        // sw
        fetch(6'h2B, 6'h00);
        tick();
        tick();
        check("sw_state", state, 5);
        check("sw_mem_write", mem_write, 1);
        check("sw_iord", iord, 1);
        tick();
        check("sw_done", state, 0);

        // addi
        fetch(6'h08, 6'h00);
        tick();
        check("addiex_state", state, 9);
        tick();
        check("addiwb_state", state, 10);
        check("addiwb_reg_write", reg_write, 1);
        check("addiwb_reg_dst", reg_dst, 0);
        tick();
        check("addi_done", state, 0);

        // j
        fetch(6'h02, 6'h00);
        tick();
        check("j_state", state, 11);
        check("j_pc_en", pc_en, 1);
        check("j_pc_src", pc_src, 2);
        tick();
        check("j_done", state, 0);

        // FETCH stalls 6 cycles with limit 4: exactly one pulse, in the fifth cycle
        mem_ready = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (mem_timeout) pulses++;
            check("to_pulse_timing", mem_timeout, (i == 4) ? 1 : 0);
            check("to_fetch_held", state, 0);
            check("to_ir_write", ir_write, 0);
            tick();
        end
        check("to_pulse_count", pulses, 1);
        mem_ready = 1'b1;
        tick();
        check("to_exit_decode", state, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net against a hung simulation.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
